decode_hazard_ctrl: RTL and testbench
=====================================

// Module: decode_hazard_ctrl
// PURPOSE
//  Decode-stage counterpart to the writeback controls. It selects the register-file read
//  addresses for the instruction in D and tracks in-flight destination registers in X/M/W.
//  It raises load-use (or no-bypass) interlocks and runs the mult/div start/ready handshake,
//  stalling F/D and injecting bubbles into D/X. Sits between the F/D latch and the D/X latch.
// PARAMETERS
//  HAS_BYPASS  1   1: stall only on load-use from X; 0: stall on any src match in X/M/W
//  REG_W       5   register address width
//  INSN_W      32  instruction width
// PORTS
//  clock          in   1      single clock; all state on rising edge
//  reset_n        in   1      asynchronous, active-low reset
//  insn_d         in   32     instruction in D
//  insn_d_valid   in   1      insn_d is a real instruction (0 = nop/flushed)
//  branch_taken   in   1      X resolved taken branch/jump; D and F are squashed this cycle
//  ctrl_readRegA  out  5      regfile read port A address
//  ctrl_readRegB  out  5      regfile read port B address
//  stall          out  1      hold PC and F/D latch
//  bubble_x       out  1      load nop into D/X this cycle
//  md_start       out  1      one-cycle start pulse to mult/div unit
//  md_is_div      out  1      valid with md_start: 1 = div, 0 = mult
//  md_ready       in   1      mult/div result ready (1-cycle pulse)
//  md_exception   in   1      mult/div overflow/div-by-0, valid with md_ready
//  md_busy        out  1      FSM in BUSY
//  md_exc_x       out  1      registered; mult/div insn now in X must write $30 (exception)
// BEHAVIOUR
//  Fields: op[31:27] rd[26:22] rs[21:17] rt[16:12] aluop[6:2].
//  Read select (combinational; both 0 when insn_d_valid=0):
//   R-type 00000: A=rs,B=rt | addi 00101, lw 01000: A=rs,B=0 | sw 00111: A=rs,B=rd
//   bne 00010, blt 00110: A=rd,B=rs | jr 00100: A=rd,B=0 | bex 10110: A=30,B=0 | else 0,0
//  Dest: R-type/addi/lw -> rd; jal 00011 -> 31; setx 10101 -> 30; else none. Dest 0 = none.
//  Source 0 never matches anything (register $0 never hazards).
//  Scoreboard: entries X,M,W each {valid,dest,is_load}. Every cycle W<=M, M<=X;
//   X <= D info if insn_d_valid & ~stall & ~branch_taken, else invalid (bubble).
//  Hazard (haz): HAS_BYPASS=1: X.valid & X.is_load & X.dest matches A or B source.
//   HAS_BYPASS=0: any of X/M/W valid with dest matching a used source.
//  branch_taken has priority: haz, md_start ignored; stall=0, bubble_x=1.
//  Mult/div FSM (md = R-type with aluop 00110 mult / 00111 div):
//   IDLE: md & valid & ~haz & ~branch_taken -> md_start=1, stall=1, bubble_x=1 -> BUSY.
//   BUSY: stall=~md_ready, bubble_x=~md_ready; on md_ready -> IDLE, insn advances to X;
//    md_exc_x<=md_exception for exactly the next cycle.
//   md_ready in IDLE is ignored. No new md_start while BUSY.
//  Otherwise stall=bubble_x=haz; haz stall lasts until the producer leaves the window.
//  Reset (async assert, sync use after deassert): FSM IDLE, scoreboard invalid,
//   stall=bubble_x=md_start=md_busy=md_exc_x=0. Mid-BUSY reset abandons the op;
//   mult/div unit shares reset_n.
// STRUCTURE
//  Package decode_pkg: opcode localparams, ALUOP_MUL/ALUOP_DIV, field LSB positions,
//   REG_LINK=31, REG_STATUS=30, scoreboard entry struct/width.
//  Sub-module decode_regsel: combinational insn -> {srcA,srcB,usesA,usesB,dest,is_load,is_md}.
//   Top keeps scoreboard regs, hazard compare, FSM.
// TESTING
//  lw $5,0($1) then add $6,$5,$2 (BYPASS=1) -> stall=1,bubble_x=1 one cycle, then add to X.
//  Same pair, dest $0 -> no stall; add $3,$4,$5 after lw $5 with BYPASS=0 -> 3 stall cycles.
//  mul $7,$1,$2; md_ready after 32 cycles -> md_start 1 pulse, stall 33 cycles, md_is_div=0.
//  div with md_exception=1 at md_ready -> md_exc_x=1 exactly next cycle, then 0.
//  branch_taken with load-use pending in D -> stall=0,bubble_x=1, X invalid next cycle.
//  reset_n low mid-BUSY -> all outputs 0 immediately; md_start only after a new md in D.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the decode-stage hazard controller.
//   Opcode / aluop encodings, instruction field positions, fixed register
//   numbers, the X/M/W scoreboard entry and the mult/div FSM state type.
package decode_pkg;

  // Field layout: op[31:27] rd[26:22] rs[21:17] rt[16:12] aluop[6:2]
  localparam int OP_LSB    = 27;
  localparam int RD_LSB    = 22;
  localparam int RS_LSB    = 17;
  localparam int RT_LSB    = 12;
  localparam int ALUOP_LSB = 2;
  localparam int FIELD_W   = 5;
  localparam int REG_AW    = 5;

  localparam logic [FIELD_W-1:0] OP_RTYPE = 5'b00000;
  localparam logic [FIELD_W-1:0] OP_BNE   = 5'b00010;
  localparam logic [FIELD_W-1:0] OP_JAL   = 5'b00011;
  localparam logic [FIELD_W-1:0] OP_JR    = 5'b00100;
  localparam logic [FIELD_W-1:0] OP_ADDI  = 5'b00101;
  localparam logic [FIELD_W-1:0] OP_BLT   = 5'b00110;
  localparam logic [FIELD_W-1:0] OP_SW    = 5'b00111;
  localparam logic [FIELD_W-1:0] OP_LW    = 5'b01000;
  localparam logic [FIELD_W-1:0] OP_SETX  = 5'b10101;
  localparam logic [FIELD_W-1:0] OP_BEX   = 5'b10110;

  localparam logic [FIELD_W-1:0] ALUOP_MUL = 5'b00110;
  localparam logic [FIELD_W-1:0] ALUOP_DIV = 5'b00111;

  localparam logic [REG_AW-1:0] REG_LINK   = 5'd31;
  localparam logic [REG_AW-1:0] REG_STATUS = 5'd30;

  // One in-flight producer; valid=0 is a bubble.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              is_load;
  } sb_entry_t;

  localparam int SB_ENTRY_W = $bits(sb_entry_t);
  localparam int SB_STAGES  = 3;  // X, M, W

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/decode_regsel.sv
// decode_regsel: combinational decode of the instruction in D.
//   insn, insn_valid      -> instruction and its valid flag
//   src_a/src_b           -> register-file read addresses (0 when unused)
//   uses_a/uses_b         -> source can hazard (nonzero register read)
//   dest                  -> destination register (0 = none)
//   is_load/is_md/is_div  -> lw, R-type mult/div, div flavour
module decode_regsel
  import decode_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter int INSN_W = 32
) (
  input  logic [INSN_W-1:0] insn,
  input  logic              insn_valid,
  output logic [REG_W-1:0]  src_a,
  output logic [REG_W-1:0]  src_b,
  output logic              uses_a,
  output logic              uses_b,
  output logic [REG_W-1:0]  dest,
  output logic              is_load,
  output logic              is_md,
  output logic              is_div
);

  logic [FIELD_W-1:0] op, aluop;
  logic [REG_W-1:0]   rd, rs, rt;

  assign op    = insn[OP_LSB    +: FIELD_W];
  assign aluop = insn[ALUOP_LSB +: FIELD_W];
  assign rd    = insn[RD_LSB    +: REG_W];
  assign rs    = insn[RS_LSB    +: REG_W];
  assign rt    = insn[RT_LSB    +: REG_W];

  // shamt and the low two bits carry nothing the decoder needs
  logic unused_fields;
  assign unused_fields = ^{insn[11:7], insn[1:0]};

  always_comb begin
    src_a   = '0;
    src_b   = '0;
    dest    = '0;
    is_load = 1'b0;
    is_md   = 1'b0;
    is_div  = 1'b0;
    if (insn_valid) begin
      case (op)
        OP_RTYPE: begin
          src_a  = rs;
          src_b  = rt;
          dest   = rd;
          is_md  = (aluop == ALUOP_MUL) || (aluop == ALUOP_DIV);
          is_div = (aluop == ALUOP_DIV);
        end
        OP_ADDI: begin src_a = rs; dest = rd; end
        OP_LW:   begin src_a = rs; dest = rd; is_load = 1'b1; end
        // store data comes from the rd field
        OP_SW:   begin src_a = rs; src_b = rd; end
        OP_BNE,
        OP_BLT:  begin src_a = rd; src_b = rs; end
        OP_JR:   src_a = rd;
        OP_BEX:  src_a = REG_STATUS;
        OP_JAL:  dest = REG_LINK;
        OP_SETX: dest = REG_STATUS;
        default: ;
      endcase
    end
  end

  // $0 never hazards
  assign uses_a = (src_a != '0);
  assign uses_b = (src_b != '0);

endmodule

// File: rtl/decode_hazard_ctrl.sv
// decode_hazard_ctrl: decode-stage interlock and mult/div handshake.
//   clock, reset_n                 -> clock, async active-low reset
//   insn_d, insn_d_valid           -> instruction in D
//   branch_taken                   -> X resolved a taken branch; D/F squashed
//   ctrl_readRegA/B                -> register-file read addresses
//   stall, bubble_x                -> hold PC/F-D latch, load nop into D/X
//   md_start, md_is_div            -> start pulse and op type to mult/div unit
//   md_ready, md_exception         -> completion pulse and its exception flag
//   md_busy, md_exc_x              -> FSM busy, exception flag for insn now in X
// A 3-deep scoreboard (X, M, W) shadows destinations of in-flight insns.
module decode_hazard_ctrl
  import decode_pkg::*;
#(
  parameter int HAS_BYPASS = 1,
  parameter int REG_W      = 5,
  parameter int INSN_W     = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [INSN_W-1:0] insn_d,
  input  logic              insn_d_valid,
  input  logic              branch_taken,
  output logic [REG_W-1:0]  ctrl_readRegA,
  output logic [REG_W-1:0]  ctrl_readRegB,
  output logic              stall,
  output logic              bubble_x,
  output logic              md_start,
  output logic              md_is_div,
  input  logic              md_ready,
  input  logic              md_exception,
  output logic              md_busy,
  output logic              md_exc_x
);

  logic [REG_W-1:0] src_a, src_b, dest;
  logic             uses_a, uses_b, is_load, is_md, is_div;

  decode_regsel #(.REG_W(REG_W), .INSN_W(INSN_W)) u_regsel (
    .insn       (insn_d),
    .insn_valid (insn_d_valid),
    .src_a      (src_a),
    .src_b      (src_b),
    .uses_a     (uses_a),
    .uses_b     (uses_b),
    .dest       (dest),
    .is_load    (is_load),
    .is_md      (is_md),
    .is_div     (is_div)
  );

  assign ctrl_readRegA = src_a;
  assign ctrl_readRegB = src_b;

  // [0]=X, [1]=M, [2]=W
  sb_entry_t [SB_STAGES-1:0] sb_q, sb_d;
  md_state_e                 state_q, state_d;
  logic                      exc_q, exc_d;
  logic                      stall_c, bubble_c, start_c, haz;

  function automatic logic src_hit(sb_entry_t e, logic [REG_W-1:0] src, logic used);
    return used && e.valid && (e.dest == src);
  endfunction

  always_comb begin
    haz = 1'b0;
    if (HAS_BYPASS != 0) begin
      // only a load in X cannot be forwarded in time
      haz = sb_q[0].valid && sb_q[0].is_load &&
            (src_hit(sb_q[0], src_a, uses_a) || src_hit(sb_q[0], src_b, uses_b));
    end else begin
      for (int s = 0; s < SB_STAGES; s++) begin
        if (src_hit(sb_q[s], src_a, uses_a) || src_hit(sb_q[s], src_b, uses_b))
          haz = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    start_c  = 1'b0;
    exc_d    = 1'b0;
    if (branch_taken) begin
      // D is squashed, so any mult/div waiting there is abandoned too
      bubble_c = 1'b1;
      state_d  = MD_IDLE;
    end else if (state_q == MD_BUSY) begin
      stall_c  = ~md_ready;
      bubble_c = ~md_ready;
      if (md_ready) begin
        state_d = MD_IDLE;
        exc_d   = md_exception;
      end
    end else if (is_md && !haz) begin
      start_c  = 1'b1;
      stall_c  = 1'b1;
      bubble_c = 1'b1;
      state_d  = MD_BUSY;
    end else begin
      stall_c  = haz;
      bubble_c = haz;
    end
  end

  always_comb begin
    sb_d[2]         = sb_q[1];
    sb_d[1]         = sb_q[0];
    sb_d[0].valid   = insn_d_valid && !stall_c && !branch_taken && (dest != '0);
    sb_d[0].dest    = dest;
    sb_d[0].is_load = is_load;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MD_IDLE;
      sb_q    <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sb_q    <= sb_d;
      exc_q   <= exc_d;
    end
  end

  // Held low while reset is asserted so nothing leaks out mid-reset.
  assign stall     = stall_c  & reset_n;
  assign bubble_x  = bubble_c & reset_n;
  assign md_start  = start_c  & reset_n;
  assign md_is_div = start_c  & is_div & reset_n;
  assign md_busy   = (state_q == MD_BUSY);
  assign md_exc_x  = exc_q;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
module tb_decode_hazard_ctrl;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // index 0: HAS_BYPASS=1, index 1: HAS_BYPASS=0
  logic [31:0] insn [2];
  logic        ivalid [2], br [2], mrdy [2], mexc [2];
  logic [4:0]  ra [2], rb [2];
  logic        st [2], bx [2], ms [2], mdiv [2], mbusy [2], mexcx [2];

  decode_hazard_ctrl #(.HAS_BYPASS(1), .REG_W(5), .INSN_W(32)) u_byp (
    .clock(clock), .reset_n(reset_n), .insn_d(insn[0]), .insn_d_valid(ivalid[0]),
    .branch_taken(br[0]), .ctrl_readRegA(ra[0]), .ctrl_readRegB(rb[0]),
    .stall(st[0]), .bubble_x(bx[0]), .md_start(ms[0]), .md_is_div(mdiv[0]),
    .md_ready(mrdy[0]), .md_exception(mexc[0]), .md_busy(mbusy[0]), .md_exc_x(mexcx[0]));

  decode_hazard_ctrl #(.HAS_BYPASS(0), .REG_W(5), .INSN_W(32)) u_nob (
    .clock(clock), .reset_n(reset_n), .insn_d(insn[1]), .insn_d_valid(ivalid[1]),
    .branch_taken(br[1]), .ctrl_readRegA(ra[1]), .ctrl_readRegB(rb[1]),
    .stall(st[1]), .bubble_x(bx[1]), .md_start(ms[1]), .md_is_div(mdiv[1]),
    .md_ready(mrdy[1]), .md_exception(mexc[1]), .md_busy(mbusy[1]), .md_exc_x(mexcx[1]));

  typedef struct packed {
    logic [4:0] ra, rb;
    logic st, bx, ms, mdiv, mbusy, mexcx;
  } exp_t;
  typedef exp_t [1:0] pair_t;

  pair_t sbq [$];
  int checks = 0, errors = 0;

  task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d %s got %0h expected %0h at %0t", d, nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  // hist[d][c%4] = {is_load, dest} of what entered X at the end of cycle c (dest 0 = nothing)
  logic [5:0]  hist [2][4];
  logic        busy [2], excf [2], adv [2];
  int          cnt [2];
  int          cyc;
  logic [4:0]  e_dst [2];
  logic        e_ld [2], e_st [2], e_ms [2];
  logic [32:0] prog0 [$], prog1 [$];
  bit          rnd = 0, br_force = 0;
  int          lat_knob = -1, exc_knob = 0;

  function automatic logic [31:0] rtype(input int rd, rs, rt, input logic [4:0] al);
    logic [4:0] d5 = rd[4:0], s5 = rs[4:0], t5 = rt[4:0];
    return {5'b00000, d5, s5, t5, 5'b00000, al, 2'b00};
  endfunction

  function automatic logic [31:0] itype(input logic [4:0] op, input int rd, rs);
    logic [4:0] d5 = rd[4:0], s5 = rs[4:0];
    return {op, d5, s5, 17'd0};
  endfunction

  // decode straight from the instruction-set tables
  function automatic void dec_m(input logic [31:0] i, input logic v,
                                output logic [4:0] a, b, dst, output logic ld, md, dv);
    logic [4:0] op = i[31:27], rd = i[26:22], rs = i[21:17], rt = i[16:12], al = i[6:2];
    a = 0; b = 0; dst = 0; ld = 0; md = 0; dv = 0;
    if (v) begin
      case (op)
        5'b00000: begin a = rs; b = rt; dst = rd; md = (al == 5'd6) || (al == 5'd7); dv = (al == 5'd7); end
        5'b00101: begin a = rs; dst = rd; end
        5'b01000: begin a = rs; dst = rd; ld = 1; end
        5'b00111: begin a = rs; b = rd; end
        5'b00010, 5'b00110: begin a = rd; b = rs; end
        5'b00100: a = rd;
        5'b10110: a = 5'd30;
        5'b00011: dst = 5'd31;
        5'b10101: dst = 5'd30;
        default: ;
      endcase
    end
  endfunction

  function automatic logic [32:0] rand_insn();
    int r = $urandom_range(0, 6), k = $urandom_range(0, 11);
    int s = $urandom_range(0, 7), t = $urandom_range(0, 7);
    logic v = ($urandom_range(0, 9) != 0);
    logic [31:0] w = $urandom;
    case (k)
      0, 1, 2: w = rtype(r, s, t, 5'd0);
      3:       w = itype(5'b00101, r, s);
      4, 5:    w = itype(5'b01000, r, s);
      6:       w = itype(5'b00111, r, s);
      7:       w = itype(($urandom_range(0, 1) != 0) ? 5'b00010 : 5'b00110, r, s);
      8:       w = itype(5'b00100, r, s);
      9:       w = {(($urandom_range(0, 1) != 0) ? 5'b00011 : 5'b10101), w[26:0]};
      10:      w = rtype(r, s, t, ($urandom_range(0, 1) != 0) ? 5'd7 : 5'd6);
      default: ;
    endcase
    return {v, w};
  endfunction

  function automatic logic [32:0] next_insn(input int d);
    if (d == 0 && prog0.size() != 0) return prog0.pop_front();
    if (d == 1 && prog1.size() != 0) return prog1.pop_front();
    if (rnd) return rand_insn();
    return 33'd0;
  endfunction

  task automatic push_both(input logic [31:0] w);
    prog0.push_back({1'b1, w});
    prog1.push_back({1'b1, w});
  endtask

  // One cycle: drive inputs, predict outputs, then advance the model past the edge.
  task automatic step();
    pair_t p;
    for (int d = 0; d < 2; d++) begin : per_dut
      logic [4:0] a, b, dst;
      logic ld, md, dv, haz;
      logic [32:0] ni;
      exp_t e;
      if (adv[d]) begin
        ni = next_insn(d);
        ivalid[d] = ni[32];
        insn[d]   = ni[31:0];
      end
      br[d] = br_force || (rnd && !busy[d] && $urandom_range(0, 19) == 0);
      if (busy[d]) mrdy[d] = (cnt[d] == 0);
      else         mrdy[d] = rnd && ($urandom_range(0, 15) == 0);
      mexc[d] = (exc_knob == 1) ? 1'b1 : (exc_knob == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      dec_m(insn[d], ivalid[d], a, b, dst, ld, md, dv);
      haz = 0;
      for (int k = 1; k <= 3; k++) begin
        logic [5:0] h = hist[d][(cyc - k) & 3];
        if (h[4:0] != 0 && (d == 1 || (k == 1 && h[5])) &&
            ((a != 0 && a == h[4:0]) || (b != 0 && b == h[4:0])))
          haz = 1;
      end
      e.ra = a; e.rb = b; e.mbusy = busy[d]; e.mexcx = excf[d]; e.ms = 0; e.mdiv = 0;
      if (br[d])        begin e.st = 0; e.bx = 1; end
      else if (busy[d]) begin e.st = !mrdy[d]; e.bx = !mrdy[d]; end
      else if (md && !haz) begin e.ms = 1; e.st = 1; e.bx = 1; e.mdiv = dv; end
      else              begin e.st = haz; e.bx = haz; end
      p[d] = e;
      e_dst[d] = dst; e_ld[d] = ld; e_st[d] = e.st; e_ms[d] = e.ms;
    end
    sbq.push_back(p);
    @(posedge clock);
    for (int d = 0; d < 2; d++) begin
      hist[d][cyc & 3] = (ivalid[d] && !e_st[d] && !br[d] && e_dst[d] != 0) ? {e_ld[d], e_dst[d]} : 6'd0;
      excf[d] = busy[d] && mrdy[d] && mexc[d] && !br[d];
      if (e_ms[d]) begin
        busy[d] = 1;
        cnt[d]  = (lat_knob < 0) ? $urandom_range(0, 6) : lat_knob;
      end else if (busy[d]) begin
        if (br[d] || mrdy[d]) busy[d] = 0;
        else cnt[d]--;
      end
      adv[d] = !e_st[d];
    end
    cyc++;
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((prog0.size() != 0 || prog1.size() != 0 || busy[0] || busy[1] || !adv[0] || !adv[1]) && n < 300) begin
      step();
      n++;
    end
    chk(0, "drain_timeout", (n >= 300), 0);
    repeat (4) step();
  endtask

  task automatic do_reset();
    for (int d = 0; d < 2; d++) begin
      ivalid[d] = 0; insn[d] = 0; br[d] = 0; mrdy[d] = 0; mexc[d] = 0;
    end
    reset_n = 0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk(d, "rst_stall", st[d], 0);
      chk(d, "rst_bubble", bx[d], 0);
      chk(d, "rst_md_start", ms[d], 0);
      chk(d, "rst_md_busy", mbusy[d], 0);
      chk(d, "rst_md_exc_x", mexcx[d], 0);
    end
    repeat (2) @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) hist[d][k] = 0;
      busy[d] = 0; excf[d] = 0; adv[d] = 1; cnt[d] = 0;
    end
    reset_n = 1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin : mon
    pair_t p;
    if (sbq.size() != 0) begin
      p = sbq.pop_front();
      for (int d = 0; d < 2; d++) begin
        chk(d, "readRegA", ra[d], p[d].ra);
        chk(d, "readRegB", rb[d], p[d].rb);
        chk(d, "stall", st[d], p[d].st);
        chk(d, "bubble_x", bx[d], p[d].bx);
        chk(d, "md_start", ms[d], p[d].ms);
        chk(d, "md_is_div", mdiv[d], p[d].mdiv);
        chk(d, "md_busy", mbusy[d], p[d].mbusy);
        chk(d, "md_exc_x", mexcx[d], p[d].mexcx);
      end
    end
  end

  // window counters over DUT outputs for the directed scenarios
  bit cnt_en = 0;
  int stall_cnt [2], bub_cnt [2], start_cnt [2], div_cnt [2], exc_cnt [2];
  always @(negedge clock) begin
    if (cnt_en) begin
      for (int d = 0; d < 2; d++) begin
        stall_cnt[d] += int'(st[d]);
        bub_cnt[d]   += int'(bx[d]);
        start_cnt[d] += int'(ms[d]);
        div_cnt[d]   += int'(mdiv[d]);
        exc_cnt[d]   += int'(mexcx[d]);
      end
    end
  end

  task automatic clr_cnt();
    for (int d = 0; d < 2; d++) begin
      stall_cnt[d] = 0; bub_cnt[d] = 0; start_cnt[d] = 0; div_cnt[d] = 0; exc_cnt[d] = 0;
    end
    cnt_en = 1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog run did not finish in time");
    $fatal(1);
  end

  initial begin
    cyc = 4;
    do_reset();

    // load-use: 1 stall with bypass, 3 without
    clr_cnt();
    push_both(itype(5'b01000, 5, 1));
    push_both(rtype(6, 5, 2, 5'd0));
    drain();
    cnt_en = 0;
    chk(0, "lw_use_stalls", stall_cnt[0], 1);
    chk(1, "lw_use_stalls", stall_cnt[1], 3);

    // load into $0 never hazards
    clr_cnt();
    push_both(itype(5'b01000, 0, 1));
    push_both(rtype(6, 0, 2, 5'd0));
    drain();
    cnt_en = 0;
    chk(0, "dest0_stalls", stall_cnt[0], 0);
    chk(1, "dest0_stalls", stall_cnt[1], 0);

    clr_cnt();
    push_both(itype(5'b01000, 5, 1));
    push_both(rtype(3, 4, 5, 5'd0));
    drain();
    cnt_en = 0;
    chk(0, "add_rt_stalls", stall_cnt[0], 1);
    chk(1, "add_rt_stalls", stall_cnt[1], 3);

    // mul with a 32-cycle unit
    lat_knob = 32; exc_knob = 2;
    clr_cnt();
    push_both(rtype(7, 1, 2, 5'd6));
    drain();
    cnt_en = 0;
    for (int d = 0; d < 2; d++) begin
      chk(d, "mul_stalls", stall_cnt[d], 33);
      chk(d, "mul_starts", start_cnt[d], 1);
      chk(d, "mul_is_div", div_cnt[d], 0);
    end

    // div raising an exception
    lat_knob = 4; exc_knob = 1;
    clr_cnt();
    push_both(rtype(8, 1, 2, 5'd7));
    drain();
    cnt_en = 0;
    for (int d = 0; d < 2; d++) begin
      chk(d, "div_exc_cycles", exc_cnt[d], 1);
      chk(d, "div_is_div", div_cnt[d], 1);
    end
    exc_knob = 0;

    // taken branch while a load-use pair sits in X/D
    clr_cnt();
    push_both(itype(5'b01000, 5, 1));
    push_both(rtype(6, 5, 2, 5'd0));
    step();
    br_force = 1;
    step();
    br_force = 0;
    drain();
    cnt_en = 0;
    for (int d = 0; d < 2; d++) begin
      chk(d, "br_stalls", stall_cnt[d], 0);
      chk(d, "br_bubbles", bub_cnt[d], 1);
    end

    // reset while the mult/div FSM is busy
    lat_knob = 32;
    push_both(rtype(7, 1, 2, 5'd6));
    repeat (6) step();
    for (int d = 0; d < 2; d++) chk(d, "busy_before_rst", mbusy[d], 1);
    prog0.delete();
    prog1.delete();
    do_reset();
    lat_knob = 3;
    clr_cnt();
    repeat (3) begin
      prog0.push_back(33'd0);
      prog1.push_back(33'd0);
    end
    push_both(rtype(9, 1, 2, 5'd6));
    drain();
    cnt_en = 0;
    for (int d = 0; d < 2; d++) chk(d, "post_rst_starts", start_cnt[d], 1);

    // randomized traffic
    lat_knob = -1;
    rnd = 1;
    repeat (3000) step();
    rnd = 0;
    drain();

    @(negedge clock);
    #1;
    chk(0, "sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
